// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port synchronous memory between the
// instruction fetch unit (IFU) and the load/store unit (LSU). Requests are
// granted round-robin, one access is in flight at a time, and read data is
// returned to the granted client MEM_LAT cycles after the memory strobe.
module mem_port_arbiter #(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned MEM_LAT = 1
) (
    input  logic              clock,
    input  logic              reset,

    // Instruction fetch client
    input  logic              ifu_req_valid,
    output logic              ifu_req_ready,
    input  logic [ADDR_W-1:0] ifu_addr,
    output logic              ifu_resp_valid,
    input  logic              ifu_resp_ready,
    output logic [DATA_W-1:0] ifu_resp_data,

    // Load/store client
    input  logic              lsu_req_valid,
    output logic              lsu_req_ready,
    input  logic [ADDR_W-1:0] lsu_addr,
    input  logic              lsu_wen,
    input  logic [DATA_W-1:0] lsu_wdata,
    input  logic [3:0]        lsu_wmask,
    output logic              lsu_resp_valid,
    input  logic              lsu_resp_ready,
    output logic [DATA_W-1:0] lsu_resp_data,

    // Memory port
    output logic              mem_valid,
    output logic              mem_wen,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [3:0]        mem_wmask,
    input  logic [DATA_W-1:0] mem_rdata
);

    typedef enum logic [1:0] {
        StIdle,
        StAccess,
        StWait,
        StResp
    } state_e;

    typedef enum logic {
        ClientIfu = 1'b0,
        ClientLsu = 1'b1
    } client_e;

    // WAIT runs for MEM_LAT cycles: the counter starts at MEM_LAT-1 and the
    // capture happens in the cycle it reads zero.
    localparam logic [2:0] LatInit = 3'(MEM_LAT - 1);

    // Sequential state
    state_e            state_q;
    client_e           last_grant_q;
    client_e           grant_q;
    logic              store_q;
    logic [2:0]        lat_cnt_q;
    logic [DATA_W-1:0] resp_data_q;
    logic              ifu_resp_valid_q;
    logic              lsu_resp_valid_q;
    logic              mem_valid_q;
    logic              mem_wen_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] mem_wdata_q;
    logic [3:0]        mem_wmask_q;

    // Combinational arbitration and request selection
    client_e           grant_sel;
    logic              any_req;
    logic              accept;
    logic              resp_ready_sel;
    logic [ADDR_W-1:0] req_addr;
    logic              req_wen;
    logic [DATA_W-1:0] req_wdata;
    logic [3:0]        req_wmask;

    // Round-robin pick: a lone requester wins, a tie goes to the client not served last.
    always_comb begin
        any_req   = ifu_req_valid | lsu_req_valid;
        grant_sel = ClientIfu;
        if (ifu_req_valid && lsu_req_valid) begin
            grant_sel = (last_grant_q == ClientLsu) ? ClientIfu : ClientLsu;
        end else if (lsu_req_valid) begin
            grant_sel = ClientLsu;
        end
        // Ready is only offered from IDLE and never while reset is held.
        accept = reset && (state_q == StIdle) && any_req;
    end

    // Ready goes to the selected client only, so valid & ready is exactly accept.
    always_comb begin
        ifu_req_ready = accept && (grant_sel == ClientIfu);
        lsu_req_ready = accept && (grant_sel == ClientLsu);
    end

    // Mux the winning client's request fields; fetches are always plain reads.
    always_comb begin
        if (grant_sel == ClientLsu) begin
            req_addr  = lsu_addr;
            req_wen   = lsu_wen;
            req_wdata = lsu_wdata;
            req_wmask = lsu_wmask;
        end else begin
            req_addr  = ifu_addr;
            req_wen   = 1'b0;
            req_wdata = '0;
            req_wmask = 4'b0000;
        end
    end

    // Response acceptance from whichever client owns the current transaction.
    always_comb begin
        resp_ready_sel = (grant_q == ClientLsu) ? lsu_resp_ready : ifu_resp_ready;
    end

    // Main FSM with registered memory-port and response outputs.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q          <= StIdle;
            last_grant_q     <= ClientLsu;
            grant_q          <= ClientIfu;
            store_q          <= 1'b0;
            lat_cnt_q        <= 3'd0;
            resp_data_q      <= '0;
            ifu_resp_valid_q <= 1'b0;
            lsu_resp_valid_q <= 1'b0;
            mem_valid_q      <= 1'b0;
            mem_wen_q        <= 1'b0;
            mem_addr_q       <= '0;
            mem_wdata_q      <= '0;
            mem_wmask_q      <= 4'b0000;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (accept) begin
                        grant_q      <= grant_sel;
                        last_grant_q <= grant_sel;
                        store_q      <= req_wen;
                        mem_valid_q  <= 1'b1;
                        mem_wen_q    <= req_wen;
                        mem_addr_q   <= req_addr;
                        mem_wdata_q  <= req_wdata;
                        mem_wmask_q  <= req_wmask;
                        state_q      <= StAccess;
                    end
                end
                StAccess: begin
                    // Single-cycle strobe: clear the port as we leave ACCESS.
                    mem_valid_q <= 1'b0;
                    mem_wen_q   <= 1'b0;
                    mem_addr_q  <= '0;
                    mem_wdata_q <= '0;
                    mem_wmask_q <= 4'b0000;
                    lat_cnt_q   <= LatInit;
                    state_q     <= StWait;
                end
                StWait: begin
                    if (lat_cnt_q == 3'd0) begin
                        resp_data_q      <= store_q ? '0 : mem_rdata;
                        ifu_resp_valid_q <= (grant_q == ClientIfu);
                        lsu_resp_valid_q <= (grant_q == ClientLsu);
                        state_q          <= StResp;
                    end else begin
                        lat_cnt_q <= lat_cnt_q - 3'd1;
                    end
                end
                StResp: begin
                    if (resp_ready_sel) begin
                        ifu_resp_valid_q <= 1'b0;
                        lsu_resp_valid_q <= 1'b0;
                        resp_data_q      <= '0;
                        state_q          <= StIdle;
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    // Drive outputs from registers, forced to zero while reset is held.
    always_comb begin
        mem_valid      = reset && mem_valid_q;
        mem_wen        = reset && mem_wen_q;
        mem_addr       = reset ? mem_addr_q : '0;
        mem_wdata      = reset ? mem_wdata_q : '0;
        mem_wmask      = reset ? mem_wmask_q : 4'b0000;
        ifu_resp_valid = reset && ifu_resp_valid_q;
        lsu_resp_valid = reset && lsu_resp_valid_q;
        ifu_resp_data  = (reset && ifu_resp_valid_q) ? resp_data_q : '0;
        lsu_resp_data  = (reset && lsu_resp_valid_q) ? resp_data_q : '0;
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a MEM_LAT=1 instance fed by a small
// memory model, plus a MEM_LAT=3 instance with hand-driven read data.
module tb_mem_port_arbiter;

    typedef struct packed {
        logic        lsu;
        logic [31:0] data;
    } exp_t;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    // MEM_LAT = 1 instance
    logic        ifu_req_valid, ifu_req_ready, ifu_resp_valid, ifu_resp_ready;
    logic [31:0] ifu_addr, ifu_resp_data;
    logic        lsu_req_valid, lsu_req_ready, lsu_wen, lsu_resp_valid, lsu_resp_ready;
    logic [31:0] lsu_addr, lsu_wdata, lsu_resp_data;
    logic [3:0]  lsu_wmask;
    logic        mem_valid, mem_wen;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_wmask;

    // MEM_LAT = 3 instance
    logic        b_ifu_req_valid, b_ifu_req_ready, b_ifu_resp_valid, b_ifu_resp_ready;
    logic [31:0] b_ifu_addr, b_ifu_resp_data;
    logic        b_lsu_req_valid, b_lsu_req_ready, b_lsu_wen, b_lsu_resp_valid;
    logic        b_lsu_resp_ready;
    logic [31:0] b_lsu_addr, b_lsu_wdata, b_lsu_resp_data;
    logic [3:0]  b_lsu_wmask;
    logic        b_mem_valid, b_mem_wen;
    logic [31:0] b_mem_addr, b_mem_wdata, b_mem_rdata;
    logic [3:0]  b_mem_wmask;

    int checks = 0;
    int errors = 0;
    exp_t sb_q[$];
    logic [31:0] junk = 32'h0BAD_0000;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1)) dut (
        .clock(clock), .reset(reset),
        .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_addr(ifu_addr),
        .ifu_resp_valid(ifu_resp_valid), .ifu_resp_ready(ifu_resp_ready),
        .ifu_resp_data(ifu_resp_data),
        .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_addr(lsu_addr),
        .lsu_wen(lsu_wen), .lsu_wdata(lsu_wdata), .lsu_wmask(lsu_wmask),
        .lsu_resp_valid(lsu_resp_valid), .lsu_resp_ready(lsu_resp_ready),
        .lsu_resp_data(lsu_resp_data),
        .mem_valid(mem_valid), .mem_wen(mem_wen), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wmask(mem_wmask), .mem_rdata(mem_rdata)
    );

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(3)) dut3 (
        .clock(clock), .reset(reset),
        .ifu_req_valid(b_ifu_req_valid), .ifu_req_ready(b_ifu_req_ready),
        .ifu_addr(b_ifu_addr), .ifu_resp_valid(b_ifu_resp_valid),
        .ifu_resp_ready(b_ifu_resp_ready), .ifu_resp_data(b_ifu_resp_data),
        .lsu_req_valid(b_lsu_req_valid), .lsu_req_ready(b_lsu_req_ready),
        .lsu_addr(b_lsu_addr), .lsu_wen(b_lsu_wen), .lsu_wdata(b_lsu_wdata),
        .lsu_wmask(b_lsu_wmask), .lsu_resp_valid(b_lsu_resp_valid),
        .lsu_resp_ready(b_lsu_resp_ready), .lsu_resp_data(b_lsu_resp_data),
        .mem_valid(b_mem_valid), .mem_wen(b_mem_wen), .mem_addr(b_mem_addr),
        .mem_wdata(b_mem_wdata), .mem_wmask(b_mem_wmask), .mem_rdata(b_mem_rdata)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'h8000_0000: return 32'h0000_0413;
            32'h8000_0004: return 32'h1234_5678;
            default:       return a ^ 32'h5A5A_0F0F;
        endcase
    endfunction

    // Memory model for the MEM_LAT=1 instance: data appears the cycle after the
    // strobe, and changing junk is driven in every other cycle.
    always @(posedge clock) begin
        junk <= junk + 32'h1;
        if (mem_valid) mem_rdata <= mem_word(mem_addr);
        else           mem_rdata <= 32'h0BAD_0000 ^ junk;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One full transaction on the MEM_LAT=1 instance; hold>0 stalls the response.
    task automatic txn(input bit lsu, input logic [31:0] addr, input logic wen,
                       input logic [31:0] wdata, input logic [3:0] wmask,
                       input int exp_lat, input int hold, input int exp_wait);
        int n;
        int nmv;
        int w;
        exp_t e;
        logic [31:0] held;
        @(negedge clock);
        if (lsu) begin
            lsu_req_valid = 1'b1; lsu_addr = addr; lsu_wen = wen;
            lsu_wdata = wdata; lsu_wmask = wmask; lsu_resp_ready = (hold == 0);
        end else begin
            ifu_req_valid = 1'b1; ifu_addr = addr; ifu_resp_ready = (hold == 0);
        end
        #1;
        w = 0;
        while (!(lsu ? lsu_req_ready : ifu_req_ready) && w < 10) begin
            @(negedge clock); #1; w++;
        end
        chk("req_ready", lsu ? lsu_req_ready : ifu_req_ready, 1);
        chk("grant_wait", w, exp_wait);
        chk("ready_excl", ifu_req_ready & lsu_req_ready, 0);
        sb_q.push_back('{lsu: lsu, data: (wen ? 32'h0 : mem_word(addr))});
        @(negedge clock);
        if (lsu) lsu_req_valid = 1'b0; else ifu_req_valid = 1'b0;
        #1;
        n = 1; nmv = 0;
        while (!(lsu ? lsu_resp_valid : ifu_resp_valid) && n < 20) begin
            if (mem_valid) begin
                nmv++;
                chk("mem_wen", mem_wen, wen);
                chk("mem_addr", mem_addr, addr);
                chk("mem_wmask", mem_wmask, wmask);
                if (wen) chk("mem_wdata", mem_wdata, wdata);
            end
            @(negedge clock); #1; n++;
        end
        chk("resp_latency", n, exp_lat);
        chk("mem_valid_count", nmv, 1);
        chk("other_resp_valid", lsu ? ifu_resp_valid : lsu_resp_valid, 0);
        chk("sb_nonempty", sb_q.size() > 0, 1);
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            chk("resp_client", lsu_resp_valid, e.lsu);
            chk("resp_data", lsu ? lsu_resp_data : ifu_resp_data, e.data);
        end
        held = lsu ? lsu_resp_data : ifu_resp_data;
        for (int i = 0; i < hold; i++) begin
            @(negedge clock); #1;
            chk("hold_valid", lsu ? lsu_resp_valid : ifu_resp_valid, 1);
            chk("hold_data", lsu ? lsu_resp_data : ifu_resp_data, held);
            chk("hold_no_mem", mem_valid, 0);
            chk("hold_no_grant", lsu ? ifu_req_ready : lsu_req_ready, 0);
            if (i == hold - 1) begin
                if (lsu) lsu_resp_ready = 1'b1; else ifu_resp_ready = 1'b1;
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired after %0d checks", checks);
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        int nmv;
        int cyc;
        int grants;
        logic g;
        exp_t e;
        logic exp_order [6];
        exp_order = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};

        // Reset held with both clients requesting: every output must stay 0.
        reset = 1'b0;
        ifu_req_valid = 1'b1; ifu_addr = 32'h8000_0000; ifu_resp_ready = 1'b1;
        lsu_req_valid = 1'b1; lsu_addr = 32'h8000_0100; lsu_wen = 1'b1;
        lsu_wdata = 32'hFFFF_FFFF; lsu_wmask = 4'hF; lsu_resp_ready = 1'b1;
        b_ifu_req_valid = 1'b0; b_ifu_addr = 32'h0; b_ifu_resp_ready = 1'b1;
        b_lsu_req_valid = 1'b0; b_lsu_addr = 32'h0; b_lsu_wen = 1'b0;
        b_lsu_wdata = 32'h0; b_lsu_wmask = 4'h0; b_lsu_resp_ready = 1'b1;
        b_mem_rdata = 32'h0;
        repeat (3) @(negedge clock);
        #1;
        chk("rst_req_ready", {ifu_req_ready, lsu_req_ready}, 0);
        chk("rst_resp_valid", {ifu_resp_valid, lsu_resp_valid}, 0);
        chk("rst_resp_data", {ifu_resp_data, lsu_resp_data}, 0);
        chk("rst_mem_ctl", {mem_valid, mem_wen, mem_wmask}, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        @(negedge clock);
        reset = 1'b1; ifu_req_valid = 1'b0; lsu_req_valid = 1'b0; lsu_wen = 1'b0;

        // IFU-only fetch, LSU store, then a stalled IFU response with LSU pending.
        txn(1'b0, 32'h8000_0000, 1'b0, 32'h0, 4'h0, 3, 0, 0);
        txn(1'b1, 32'h8000_0100, 1'b1, 32'hDEAD_BEEF, 4'b0011, 3, 0, 0);
        lsu_req_valid = 1'b1; lsu_addr = 32'h8000_0008; lsu_wen = 1'b0;
        txn(1'b0, 32'h8000_0004, 1'b0, 32'h0, 4'h0, 3, 5, 0);
        txn(1'b1, 32'h8000_0008, 1'b0, 32'h0, 4'h0, 3, 0, 0);

        // Reset while an LSU load is in WAIT.
        @(negedge clock);
        lsu_req_valid = 1'b1; lsu_addr = 32'h8000_0010; lsu_wen = 1'b0; #1;
        chk("rw_lsu_ready", lsu_req_ready, 1);
        @(negedge clock); lsu_req_valid = 1'b0; #1;
        chk("rw_access", mem_valid, 1);
        @(negedge clock); #1;
        chk("rw_in_wait", {mem_valid, lsu_resp_valid}, 0);
        reset = 1'b0; #1;
        chk("rw_zero_ctl", {ifu_req_ready, lsu_req_ready, ifu_resp_valid, lsu_resp_valid,
                            mem_valid, mem_wen, mem_wmask}, 0);
        chk("rw_zero_addr", mem_addr, 0);
        chk("rw_zero_data", {ifu_resp_data, lsu_resp_data}, 0);
        @(negedge clock); reset = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clock); #1;
            chk("rw_no_resp", {lsu_resp_valid, ifu_resp_valid, mem_valid}, 0);
        end
        txn(1'b0, 32'h8000_0000, 1'b0, 32'h0, 4'h0, 3, 0, 0);

        // Fresh reset, then both clients continuously valid for six grants.
        @(negedge clock); reset = 1'b0;
        @(negedge clock); reset = 1'b1;
        ifu_addr = 32'h8000_0040; lsu_addr = 32'h8000_0080; lsu_wen = 1'b0;
        ifu_resp_ready = 1'b1; lsu_resp_ready = 1'b1;
        grants = 0; cyc = 0;
        while ((grants < 6 || sb_q.size() > 0) && cyc < 200) begin
            @(negedge clock);
            if (cyc == 0) begin ifu_req_valid = 1'b1; lsu_req_valid = 1'b1; end
            if (grants >= 6) begin ifu_req_valid = 1'b0; lsu_req_valid = 1'b0; end
            #1;
            chk("fair_ready_excl", ifu_req_ready & lsu_req_ready, 0);
            if (ifu_req_ready || lsu_req_ready) begin
                g = lsu_req_ready;
                chk("fair_grant_bound", grants < 6, 1);
                if (grants < 6) chk("fair_grant_order", g, exp_order[grants]);
                sb_q.push_back('{lsu: g, data: mem_word(g ? lsu_addr : ifu_addr)});
                grants++;
            end
            if (ifu_resp_valid || lsu_resp_valid) begin
                chk("fair_sb_nonempty", sb_q.size() > 0, 1);
                if (sb_q.size() > 0) begin
                    e = sb_q.pop_front();
                    chk("fair_resp_client", lsu_resp_valid, e.lsu);
                    chk("fair_resp_data", lsu_resp_valid ? lsu_resp_data : ifu_resp_data,
                        e.data);
                end
            end
            cyc++;
        end
        chk("fair_grants", grants, 6);
        chk("fair_drained", sb_q.size(), 0);

        // MEM_LAT=3 load; read data only valid in the last WAIT cycle.
        @(negedge clock);
        b_lsu_req_valid = 1'b1; b_lsu_addr = 32'h8000_0020; b_lsu_wen = 1'b0; #1;
        chk("lat3_ready", b_lsu_req_ready, 1);
        sb_q.push_back('{lsu: 1'b1, data: 32'hCAFE_0001});
        n = 0; nmv = 0;
        while (!b_lsu_resp_valid && n < 15) begin
            @(negedge clock);
            n++;
            b_lsu_req_valid = 1'b0;
            b_mem_rdata = (n == 4) ? 32'hCAFE_0001 : (32'h7700_0000 | 32'(n));
            #1;
            if (b_mem_valid) begin
                nmv++;
                chk("lat3_mem_addr", b_mem_addr, 32'h8000_0020);
                chk("lat3_mem_wen", b_mem_wen, 0);
            end
        end
        chk("lat3_latency", n, 5);
        chk("lat3_mem_count", nmv, 1);
        chk("lat3_other_resp", b_ifu_resp_valid, 0);
        chk("lat3_sb_nonempty", sb_q.size() > 0, 1);
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            chk("lat3_resp_data", b_lsu_resp_data, e.data);
        end
        @(negedge clock); #1;
        chk("lat3_idle", {b_lsu_resp_valid, b_ifu_req_ready, b_mem_valid, b_mem_wdata,
                          b_mem_wmask, b_ifu_resp_data}, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
